// File: rtl/ps2_command_tx.sv
// Host-to-device command transmitter for a PS/2 port: inhibits the bus, shifts out
// start, eight data bits LSB first, odd parity and stop, then checks the device ACK.
module ps2_command_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned EDGE_TIMEOUT   = 100000
) (
  input  logic       inclock,
  input  logic       resetn,
  input  logic       send_command,
  input  logic [7:0] the_command,
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  output logic       busy,
  output logic       command_sent,
  output logic       error_timeout,
  output logic       error_no_ack
);

  localparam int unsigned MaxAB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES
                                                                     : START_TIMEOUT;
  localparam int unsigned MaxCnt = (MaxAB > EDGE_TIMEOUT) ? MaxAB : EDGE_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  // Start bit goes low one cycle before the clock is released.
  localparam int unsigned InhibitLast = INHIBIT_CYCLES - 1;
  localparam int unsigned DataLowAt   = (INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0;
  localparam logic        StartAtOnce = (INHIBIT_CYCLES < 2);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRequest,
    StXfer,
    StWaitAck,
    StWaitIdle
  } state_e;

  state_e          state_q;
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            dat_meta_q, dat_sync_q;
  logic            clk_oe_q, dat_oe_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_idx_q;
  logic [8:0]      tx_q;
  logic            busy_q, sent_q, timeout_q, no_ack_q;

  logic clk_fall;
  logic start_expired;
  logic edge_expired;

  // Open-drain drivers: only ever pull low or float.
  assign ps2_clock = clk_oe_q ? 1'b0 : 1'bz;
  assign ps2_data  = dat_oe_q ? 1'b0 : 1'bz;

  assign busy          = busy_q;
  assign command_sent  = sent_q;
  assign error_timeout = timeout_q;
  assign error_no_ack  = no_ack_q;

  assign clk_fall      = clk_prev_q & ~clk_sync_q;
  assign start_expired = (cnt_q == CntW'(START_TIMEOUT - 1));
  assign edge_expired  = (cnt_q == CntW'(EDGE_TIMEOUT - 1));

  // Idle bus level is high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clock;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= '0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      timeout_q <= 1'b0;
      no_ack_q  <= 1'b0;
    end else begin
      sent_q    <= 1'b0;
      timeout_q <= 1'b0;
      no_ack_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          clk_oe_q  <= 1'b0;
          dat_oe_q  <= 1'b0;
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (send_command) begin
            tx_q     <= {~^the_command, the_command};
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            dat_oe_q <= StartAtOnce;
            state_q  <= StInhibit;
          end
        end

        StInhibit: begin
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(DataLowAt)) begin
            dat_oe_q <= 1'b1;
          end
          if (cnt_q == CntW'(InhibitLast)) begin
            clk_oe_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= StRequest;
          end
        end

        // The first device edge already clocks out data bit 0.
        StRequest: begin
          cnt_q <= cnt_q + CntW'(1);
          if (clk_fall) begin
            dat_oe_q  <= ~tx_q[0];
            tx_q      <= {1'b0, tx_q[8:1]};
            bit_idx_q <= '0;
            cnt_q     <= '0;
            state_q   <= StXfer;
          end else if (start_expired) begin
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end
        end

        StXfer: begin
          cnt_q <= cnt_q + CntW'(1);
          if (clk_fall) begin
            cnt_q <= '0;
            if (bit_idx_q == 4'd8) begin
              dat_oe_q <= 1'b0;
              state_q  <= StWaitAck;
            end else begin
              dat_oe_q  <= ~tx_q[0];
              tx_q      <= {1'b0, tx_q[8:1]};
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end else if (edge_expired) begin
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end
        end

        StWaitAck: begin
          cnt_q <= cnt_q + CntW'(1);
          if (clk_fall) begin
            cnt_q <= '0;
            if (dat_sync_q) begin
              busy_q   <= 1'b0;
              no_ack_q <= 1'b1;
              state_q  <= StIdle;
            end else begin
              state_q <= StWaitIdle;
            end
          end else if (edge_expired) begin
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end
        end

        StWaitIdle: begin
          cnt_q <= cnt_q + CntW'(1);
          if (clk_sync_q && dat_sync_q) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b1;
            state_q <= StIdle;
          end else if (clk_fall) begin
            cnt_q <= '0;
          end else if (edge_expired) begin
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          cnt_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: a PS/2 device model drives the bus, a scoreboard checks outcomes.
module tb_ps2_command_tx;

  localparam int unsigned Inh     = 50;
  localparam int unsigned StartTo = 200;
  localparam int unsigned EdgeTo  = 100;

  localparam int KSent    = 0;
  localparam int KTimeout = 1;
  localparam int KNoAck   = 2;

  typedef struct {
    int         kind;
    logic [7:0] cmd;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       send_command;
  logic [7:0] the_command;
  wire        ps2_clock;
  wire        ps2_data;
  logic       busy, command_sent, error_timeout, error_no_ack;

  logic       dev_clk_low;
  logic       dev_data_low;
  logic [9:0] dev_bits;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rel_cyc, last_fall_cyc, last_pulse_cyc;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_kind;

  pullup (ps2_clock);
  pullup (ps2_data);
  assign ps2_clock = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data  = dev_data_low ? 1'b0 : 1'bz;

  ps2_command_tx #(
    .INHIBIT_CYCLES(Inh),
    .START_TIMEOUT (StartTo),
    .EDGE_TIMEOUT  (EdgeTo)
  ) dut (
    .inclock      (clk),
    .resetn       (resetn),
    .send_command (send_command),
    .the_command  (the_command),
    .ps2_clock    (ps2_clock),
    .ps2_data     (ps2_data),
    .busy         (busy),
    .command_sent (command_sent),
    .error_timeout(error_timeout),
    .error_no_ack (error_no_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_range(input string name, input int act, input int lo,
                                      input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endfunction

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic int model_parity(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1 : 0;
  endfunction

  // Monitor: every completion pulse consumes one expected outcome.
  always @(negedge clk) begin
    if (resetn && (command_sent || error_timeout || error_no_ack)) begin
      last_pulse_cyc = cyc;
      check("one_pulse", int'(command_sent) + int'(error_timeout) + int'(error_no_ack), 1);
      check("busy_at_pulse", int'(busy), 0);
      mon_kind = command_sent ? KSent : (error_timeout ? KTimeout : KNoAck);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d expected none", mon_kind);
      end else begin
        mon_e = exp_q.pop_front();
        check("outcome_kind", mon_kind, mon_e.kind);
        if (mon_e.kind == KSent && mon_kind == KSent) begin
          check("dev_byte", int'(dev_bits[7:0]), int'(mon_e.cmd));
          check("dev_parity", int'(dev_bits[8]), model_parity(mon_e.cmd));
          check("dev_stop", int'(dev_bits[9]), 1);
        end
      end
    end
  end

  // Device side: checks the request phase, then clocks n_pulses bits and optionally ACKs.
  task automatic device_run(input int n_pulses, input int ack_mode);
    int t, inh, dlow;
    dev_bits = '0;
    t = 0;
    while (ps2_clock != 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    inh  = 0;
    dlow = 0;
    while (ps2_clock == 1'b0 && inh < 5000) begin
      inh++;
      if (ps2_data == 1'b0) dlow++;
      @(negedge clk);
    end
    check("inhibit_len", inh, Inh);
    check("start_last_cycle_only", dlow, 1);
    check("start_bit", int'(ps2_data), 0);
    rel_cyc = cyc;
    if (n_pulses == 0) return;
    repeat ($urandom_range(5, 40)) @(negedge clk);
    for (int k = 0; k < n_pulses; k++) begin
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      dev_bits[k] = ps2_data;
      repeat (10) @(negedge clk);
    end
    if (ack_mode != 0) begin
      if (ack_mode == 1) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  // ack_mode: 0 = device stops after n_pulses, 1 = ACK, 2 = no ACK.
  task automatic run_txn(input logic [7:0] cmd, input int n_pulses, input int ack_mode,
                         input bit do_reset);
    exp_t e;
    int   t;
    @(negedge clk);
    the_command  = cmd;
    send_command = 1'b1;
    if (!do_reset) begin
      e.cmd  = cmd;
      e.kind = (ack_mode == 1) ? KSent : ((ack_mode == 2) ? KNoAck : KTimeout);
      exp_q.push_back(e);
    end
    last_pulse_cyc = -1;
    @(negedge clk);
    send_command = 1'b0;
    check("busy_rise", int'(busy), 1);
    fork
      device_run(n_pulses, ack_mode);
      begin
        repeat (7) @(negedge clk);
        the_command  = ~cmd;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
      end
    join
    if (do_reset) begin
      check("pre_reset_data_low", int'(ps2_data), 0);
      #2 resetn = 1'b0;
      #1;
      check("async_rst_data", int'(ps2_data), 1);
      check("async_rst_clock", int'(ps2_clock), 1);
      check("async_rst_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      return;
    end
    t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("busy_drop", int'(busy), 0);
    @(negedge clk);
    if (ack_mode == 0 && n_pulses == 0)
      check("start_timeout_delay", last_pulse_cyc - rel_cyc, StartTo);
    else if (ack_mode == 0)
      check_range("edge_timeout_delay", last_pulse_cyc - last_fall_cyc, EdgeTo, EdgeTo + 4);
    check("idle_clock_released", int'(ps2_clock), 1);
    check("idle_data_released", int'(ps2_data), 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mode;
    resetn       = 1'b0;
    send_command = 1'b0;
    the_command  = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'(command_sent) + int'(error_timeout) + int'(error_no_ack), 0);
    check("rst_clock", int'(ps2_clock), 1);
    check("rst_data", int'(ps2_data), 1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    run_txn(8'hED, 10, 1, 1'b0);
    run_txn(8'hF4, 10, 1, 1'b0);
    run_txn(8'($urandom), 0, 0, 1'b0);
    run_txn(8'($urandom), 4, 0, 1'b0);
    run_txn(8'($urandom), 10, 2, 1'b0);
    run_txn(8'h00, 5, 0, 1'b1);
    run_txn(8'hFF, 10, 1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      mode = int'($urandom_range(0, 3));
      unique case (mode)
        0:       run_txn(8'($urandom), 10, 1, 1'b0);
        1:       run_txn(8'($urandom), 10, 2, 1'b0);
        2:       run_txn(8'($urandom), 0, 0, 1'b0);
        default: run_txn(8'($urandom), int'($urandom_range(1, 10)), 0, 1'b0);
      endcase
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_command_tx.md
PS2_COMMAND_TX -- requirements
Module: ps2_command_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, inclock cycles ps2_clock is held low before a request (100 us at 50 MHz).
REQ-002 SHALL have parameter START_TIMEOUT, default 750000, maximum inclock cycles from clock release to first device falling edge (15 ms).
REQ-003 SHALL have parameter EDGE_TIMEOUT, default 100000, maximum inclock cycles between consecutive device falling edges (2 ms).
REQ-004 SHALL have port inclock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port send_command  input  1  one-cycle request; accepted only in IDLE.
REQ-007 SHALL have port the_command  input  8  command byte, sampled when the request is accepted.
REQ-008 SHALL have port ps2_clock  inout  1  open-drain; driven 0 or high-Z, never 1.
REQ-009 SHALL have port ps2_data  inout  1  open-drain; driven 0 or high-Z, never 1.
REQ-010 SHALL have port busy  output  1  high from accept until return to IDLE.
REQ-011 SHALL have port command_sent  output  1  one-cycle pulse on ACK-terminated success.
REQ-012 SHALL have port error_timeout  output  1  one-cycle pulse on START_TIMEOUT or EDGE_TIMEOUT expiry.
REQ-013 SHALL have port error_no_ack  output  1  one-cycle pulse when ps2_data is sampled high in the ACK slot.

Function
REQ-014 SHALL pass ps2_clock and ps2_data through 2-flop synchronizers; a falling edge is sync'd clock 1 then 0 on consecutive cycles.
REQ-015 SHALL implement states IDLE, INHIBIT, REQUEST, XFER, WAIT_ACK, WAIT_IDLE.
REQ-016 IDLE: both lines high-Z; send_command=1 latches the_command, computes odd parity (~^the_command), goes to INHIBIT next cycle.
REQ-017 INHIBIT: drive ps2_clock low for exactly INHIBIT_CYCLES cycles; drive ps2_data low (start bit) in the final cycle; then REQUEST.
REQ-018 REQUEST: release ps2_clock, keep ps2_data low; first falling edge goes to XFER with bit index 0; no edge within START_TIMEOUT cycles goes to IDLE with error_timeout.
REQ-019 XFER: falling edges 1-8 drive data bits 0-7 LSB first (0 = drive low, 1 = high-Z); edge 9 drives parity; edge 10 releases ps2_data (stop) and goes to WAIT_ACK.
REQ-020 Each new data value SHALL take effect on the cycle after the synchronized falling edge is detected and hold until the next falling edge.
REQ-021 WAIT_ACK: on the next falling edge sample synchronized ps2_data; 0 goes to WAIT_IDLE, 1 pulses error_no_ack and goes to IDLE.
REQ-022 WAIT_IDLE: when synchronized clock and data are both 1, pulse command_sent and go to IDLE.
REQ-023 The edge-timeout counter SHALL clear on every falling edge in XFER, WAIT_ACK and WAIT_IDLE; reaching EDGE_TIMEOUT releases both lines, pulses error_timeout, goes to IDLE.
REQ-024 send_command while busy=1 SHALL be ignored; the latched command SHALL not change.
REQ-025 Exactly one of command_sent, error_timeout, error_no_ack SHALL pulse per accepted request; busy SHALL fall in the same cycle as that pulse.
REQ-026 Counters SHALL be wide enough for max(INHIBIT_CYCLES, START_TIMEOUT, EDGE_TIMEOUT) with no wrap.

Reset
REQ-027 resetn=0 SHALL immediately, without waiting for inclock, force IDLE, high-Z on both lines, busy=0, command_sent=0, error_timeout=0, error_no_ack=0, all counters and bit index 0.
REQ-028 Reset during any transfer SHALL abort it with no completion pulse; the first request after resetn rises SHALL proceed normally.

Verification
REQ-029 Device model, command 8'hED, INHIBIT_CYCLES=50 -> clock low 50 cycles, data bits 1,0,1,1,0,1,1,1 then parity 1, stop high-Z, ACK 0 -> one command_sent pulse, busy=0.
REQ-030 Command 8'hF4 -> model captures 8'hF4 with parity bit 0; command_sent=1 once.
REQ-031 No device clock after release, START_TIMEOUT=200 -> error_timeout pulse 200 cycles after release, both lines high-Z.
REQ-032 Device stops clocking after bit 3, EDGE_TIMEOUT=100 -> error_timeout after 100 cycles, no command_sent.
REQ-033 Device leaves data high in ACK slot -> error_no_ack pulse, no command_sent.
REQ-034 resetn=0 mid-XFER, then new send_command 8'hFF -> lines released asynchronously, second transfer completes with command_sent, model receives 8'hFF.
